id_ex_operand_stage: RTL and testbench

- Single-entry ID/EX pipeline register directly downstream of the register file.
- Captures the combinational regfile read data rd1/rd2 with the decoded instruction fields.
- Applies write-through bypass for a same-cycle writeback. While an entry is held under backpressure, it refreshes that entry's operands from later writebacks.
- Detects load-use hazards and stalls decode. Presents a valid/ready handshake to EX.

---
 rtl/riscv_pipe_pkg.sv | 24 ++
 rtl/wb_bypass_mux.sv | 20 ++
 rtl/id_ex_operand_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Purpose: shared ID/EX pipeline definitions (register index width, x0, control width, payload struct).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    localparam int REG_IDX_W      = 5;
    localparam logic [REG_IDX_W-1:0] X0 = '0;
    localparam int CTRL_W_DEFAULT = 16;
    localparam int XLEN           = 32;

    // ID/EX payload as seen by the EX stage at default widths.
    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [REG_IDX_W-1:0]      rs1;
        logic [REG_IDX_W-1:0]      rs2;
        logic [REG_IDX_W-1:0]      rd;
        logic [XLEN-1:0]           imm;
        logic [CTRL_W_DEFAULT-1:0] ctrl;
        logic                      is_load;
        logic [XLEN-1:0]           a;
        logic [XLEN-1:0]           b;
    } id_ex_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Purpose: selects writeback data over a stale operand when the writeback targets idx (never for x0).
// Latency: combinational.
// Backpressure: none.
// Ports: idx/rf_data = operand index and its current value; wb_we/wb_rd/wb_wd = writeback port; data = selected operand.
module wb_bypass_mux
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [WIDTH-1:0]     rf_data,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]     wb_wd,
    output logic [WIDTH-1:0]     data
);

    assign data = (wb_we && (wb_rd != X0) && (wb_rd == idx)) ? wb_wd : rf_data;

endmodule

// File: rtl/id_ex_operand_stage.sv
// Purpose: single-entry ID/EX register with writeback bypass, held-operand refresh and load-use stall.
// Latency: 1 cycle from accept (id_valid & id_ready) to ex_valid.
// Backpressure: holds the entry while !ex_ready; id_ready drops when full and not draining, or on load-use hazard.
// Ports: clk/reset; id_* decode side (valid/ready + fields); rf_rd1/rf_rd2 regfile read data;
//        wb_* writeback port; flush squash; ex_* registered entry with valid/ready; load_use_stall.
module id_ex_operand_stage
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [WIDTH-1:0]     id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [WIDTH-1:0]     id_imm,
    input  logic [CTRL_W-1:0]    id_ctrl,
    input  logic                 id_is_load,
    input  logic [WIDTH-1:0]     rf_rd1,
    input  logic [WIDTH-1:0]     rf_rd2,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]     wb_wd,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [WIDTH-1:0]     ex_pc,
    output logic [WIDTH-1:0]     ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic                 ex_is_load,
    output logic [WIDTH-1:0]     ex_a,
    output logic [WIDTH-1:0]     ex_b,
    output logic                 load_use_stall
);

    // Same field order as id_ex_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0]     pc;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [WIDTH-1:0]     imm;
        logic [CTRL_W-1:0]    ctrl;
        logic                 is_load;
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     b;
    } payload_t;

    logic     ex_valid_q;
    payload_t ex_q;

    logic hazard;
    logic hold;
    logic accept;

    logic [REG_IDX_W-1:0] mux_idx_a, mux_idx_b;
    logic [WIDTH-1:0]     mux_src_a, mux_src_b;
    logic [WIDTH-1:0]     byp_a, byp_b;

    assign hazard = id_valid && ex_valid_q && ex_q.is_load && (ex_q.rd != X0) &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    assign hold     = ex_valid_q && !ex_ready;
    assign id_ready = (!ex_valid_q || ex_ready) && !hazard;
    assign accept   = id_valid && id_ready;

    // While holding, id_ready is low so no capture can happen; the two muxes
    // are re-pointed at the held entry to refresh its operands instead.
    assign mux_idx_a = hold ? ex_q.rs1 : id_rs1;
    assign mux_idx_b = hold ? ex_q.rs2 : id_rs2;
    assign mux_src_a = hold ? ex_q.a   : rf_rd1;
    assign mux_src_b = hold ? ex_q.b   : rf_rd2;

    wb_bypass_mux #(.WIDTH(WIDTH)) u_byp_a (
        .idx     (mux_idx_a),
        .rf_data (mux_src_a),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_wd   (wb_wd),
        .data    (byp_a)
    );

    wb_bypass_mux #(.WIDTH(WIDTH)) u_byp_b (
        .idx     (mux_idx_b),
        .rf_data (mux_src_b),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_wd   (wb_wd),
        .data    (byp_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q   <= 1'b1;
            ex_q.pc      <= id_pc;
            ex_q.rs1     <= id_rs1;
            ex_q.rs2     <= id_rs2;
            ex_q.rd      <= id_rd;
            ex_q.imm     <= id_imm;
            ex_q.ctrl    <= id_ctrl;
            ex_q.is_load <= id_is_load;
            ex_q.a       <= byp_a;
            ex_q.b       <= byp_b;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_q <= 1'b0;
        end else if (hold) begin
            ex_q.a <= byp_a;
            ex_q.b <= byp_b;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_q.pc;
    assign ex_imm         = ex_q.imm;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_rd          = ex_q.rd;
    assign ex_ctrl        = ex_q.ctrl;
    assign ex_is_load     = ex_q.is_load;
    assign ex_a           = ex_q.a;
    assign ex_b           = ex_q.b;
    assign load_use_stall = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic        id_is_load;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl;
    logic        ex_is_load;
    logic [31:0] ex_a, ex_b;
    logic        load_use_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_imm         (id_imm),
        .id_ctrl        (id_ctrl),
        .id_is_load     (id_is_load),
        .rf_rd1         (rf_rd1),
        .rf_rd2         (rf_rd2),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_wd          (wb_wd),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_ctrl        (ex_ctrl),
        .ex_is_load     (ex_is_load),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .load_use_stall (load_use_stall)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_imm = 0; id_ctrl = 0; id_is_load = 0; rf_rd1 = 0; rf_rd2 = 0;
        wb_we = 0; wb_rd = 0; wb_wd = 0; flush = 0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic ld,
                            input logic [31:0] d1, input logic [31:0] d2);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_imm = pc + 32'h1000; id_ctrl = pc[15:0] ^ 16'h5A5A; id_is_load = ld;
        rf_rd1 = d1; rf_rd2 = d2;
    endtask

    task automatic test_reset();
        idle_inputs();
        ex_ready = 1;
        reset = 1;
        step(); step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ex_valid); end
        reset = 0;
        step();
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got=%0b want=1", id_ready); end
        // Load a non-zero entry, then assert reset mid-cycle.
        ex_ready = 0;
        drive_id(32'h100, 5'd9, 5'd10, 5'd11, 1'b1, 32'hDEAD, 32'hBEEF);
        step();
        idle_inputs();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin bad++; $display("FAIL reset_preload got valid=%0b pc=%h want 1/100", ex_valid, ex_pc); end
        #2 reset = 1;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_async_valid got=%0b want=0", ex_valid); end
        total++;
        if ({ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_is_load, ex_a, ex_b} !== '0) begin
            bad++; $display("FAIL reset_async_payload pc=%h imm=%h rd=%0d ld=%0b a=%h b=%h want all 0",
                            ex_pc, ex_imm, ex_rd, ex_is_load, ex_a, ex_b);
        end
        step();
        reset = 0;
        ex_ready = 1;
        step();
        total++; if (id_ready !== 1'b1 || ex_valid !== 1'b0) begin bad++; $display("FAIL reset_release got ready=%0b valid=%0b want 1/0", id_ready, ex_valid); end
    endtask

    task automatic test_plain_transfer();
        ex_ready = 1;
        drive_id(32'h200, 5'd3, 5'd4, 5'd12, 1'b0, 32'h11, 32'h44);
        step();
        total++; if (ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_pc !== 32'h200) begin bad++; $display("FAIL plain_first got v=%0b a=%h pc=%h want 1/11/200", ex_valid, ex_a, ex_pc); end
        total++; if (ex_imm !== 32'h1200 || ex_ctrl !== 16'h585A || ex_rd !== 5'd12 || ex_b !== 32'h44) begin bad++; $display("FAIL plain_fields got imm=%h ctrl=%h rd=%0d b=%h want 1200/585A/12/44", ex_imm, ex_ctrl, ex_rd, ex_b); end
        drive_id(32'h204, 5'd6, 5'd7, 5'd13, 1'b0, 32'h22, 32'h77);
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", id_ready); end
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_a !== 32'h22 || ex_rs1 !== 5'd6) begin bad++; $display("FAIL b2b_second got v=%0b pc=%h a=%h rs1=%0d want 1/204/22/6", ex_valid, ex_pc, ex_a, ex_rs1); end
        drive_id(32'h208, 5'd8, 5'd9, 5'd14, 1'b0, 32'h33, 32'h99);
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h208 || ex_b !== 32'h99) begin bad++; $display("FAIL b2b_third got v=%0b pc=%h b=%h want 1/208/99", ex_valid, ex_pc, ex_b); end
        idle_inputs();
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL plain_drain got=%0b want=0", ex_valid); end
    endtask

    task automatic test_bypass();
        ex_ready = 1;
        drive_id(32'h240, 5'd1, 5'd5, 5'd2, 1'b0, 32'h01, 32'hAA);
        wb_we = 1; wb_rd = 5'd5; wb_wd = 32'hBB;
        step();
        total++; if (ex_b !== 32'hBB || ex_a !== 32'h01) begin bad++; $display("FAIL bypass_rs2 got a=%h b=%h want 01/BB", ex_a, ex_b); end
        drive_id(32'h244, 5'd5, 5'd0, 5'd2, 1'b0, 32'h66, 32'h0);
        wb_we = 1; wb_rd = 5'd0; wb_wd = 32'hCC;
        step();
        total++; if (ex_b !== 32'h0 || ex_a !== 32'h66) begin bad++; $display("FAIL bypass_x0 got a=%h b=%h want 66/0", ex_a, ex_b); end
        drive_id(32'h248, 5'd0, 5'd0, 5'd2, 1'b0, 32'h0, 32'h0);
        wb_we = 1; wb_rd = 5'd0; wb_wd = 32'hCC;
        step();
        total++; if (ex_a !== 32'h0 || ex_b !== 32'h0) begin bad++; $display("FAIL bypass_x0_both got a=%h b=%h want 0/0", ex_a, ex_b); end
        idle_inputs();
        step();
    endtask

    task automatic test_held_refresh();
        ex_ready = 0;
        drive_id(32'h300, 5'd7, 5'd8, 5'd15, 1'b0, 32'h10, 32'h20);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            id_valid = 1; id_pc = 32'h304; id_rs1 = 5'd1; id_rs2 = 5'd2;
            #1;
            total++; if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_a !== 32'h10) begin bad++; $display("FAIL hold_cycle%0d got rdy=%0b v=%0b a=%h want 0/1/10", i, id_ready, ex_valid, ex_a); end
            step();
        end
        id_valid = 0;
        wb_we = 1; wb_rd = 5'd7; wb_wd = 32'h55;
        step();
        wb_we = 0;
        total++; if (ex_a !== 32'h55) begin bad++; $display("FAIL refresh_a got=%h want=55", ex_a); end
        total++; if (ex_pc !== 32'h300 || ex_b !== 32'h20 || ex_valid !== 1'b1) begin bad++; $display("FAIL refresh_others got pc=%h b=%h v=%0b want 300/20/1", ex_pc, ex_b, ex_valid); end
        wb_we = 1; wb_rd = 5'd0; wb_wd = 32'h77;
        step();
        wb_we = 0;
        total++; if (ex_a !== 32'h55 || ex_b !== 32'h20) begin bad++; $display("FAIL refresh_x0 got a=%h b=%h want 55/20", ex_a, ex_b); end
        ex_ready = 1;
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL refresh_drain got=%0b want=0", ex_valid); end
    endtask

    task automatic test_load_use();
        ex_ready = 1;
        drive_id(32'h400, 5'd1, 5'd2, 5'd4, 1'b1, 32'h0, 32'h0);
        step();
        drive_id(32'h404, 5'd4, 5'd3, 5'd6, 1'b0, 32'h44, 32'h33);
        #1;
        total++; if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got stall=%0b rdy=%0b want 1/0", load_use_stall, id_ready); end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0b want=0", ex_valid); end
        total++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin bad++; $display("FAIL lu_release got stall=%0b rdy=%0b want 0/1", load_use_stall, id_ready); end
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h404 || ex_a !== 32'h44) begin bad++; $display("FAIL lu_consumer got v=%0b pc=%h a=%h want 1/404/44", ex_valid, ex_pc, ex_a); end
        // Load writing x0 never stalls.
        drive_id(32'h500, 5'd1, 5'd2, 5'd0, 1'b1, 32'h0, 32'h0);
        step();
        drive_id(32'h504, 5'd0, 5'd0, 5'd6, 1'b0, 32'h0, 32'h0);
        #1;
        total++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin bad++; $display("FAIL lu_x0 got stall=%0b rdy=%0b want 0/1", load_use_stall, id_ready); end
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h504) begin bad++; $display("FAIL lu_x0_next got v=%0b pc=%h want 1/504", ex_valid, ex_pc); end
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        ex_ready = 0;
        drive_id(32'h600, 5'd1, 5'd2, 5'd3, 1'b0, 32'h1, 32'h2);
        step();
        drive_id(32'h604, 5'd1, 5'd2, 5'd3, 1'b0, 32'h1, 32'h2);
        flush = 1;
        step();
        flush = 0;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_held got=%0b want=0", ex_valid); end
        // Flush coinciding with a real accept: id_ready stays up, entry discarded.
        ex_ready = 1;
        drive_id(32'h608, 5'd1, 5'd2, 5'd3, 1'b0, 32'h1, 32'h2);
        flush = 1;
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_id_ready got=%0b want=1", id_ready); end
        step();
        flush = 0;
        idle_inputs();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_accept got=%0b want=0", ex_valid); end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got v=%0b pc=%h want 0", ex_valid, ex_pc); end
    endtask

    initial begin
        idle_inputs();
        ex_ready = 1;
        reset = 1;
        test_reset();
        test_plain_transfer();
        test_bypass();
        test_held_refresh();
        test_load_use();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
